// File: rtl/iob_asym_fifo_pkg.sv
// Shared sizing helpers for the asymmetric (narrow-write / wide-read) FIFO controller.
package iob_asym_fifo_pkg;

  // almost_empty stays asserted until at least this many complete wide words are stored
  localparam int unsigned ALMOST_EMPTY_WIDE = 2;

  function automatic int unsigned calc_ratio(input int unsigned r_w, input int unsigned w_w);
    return r_w / w_w;
  endfunction

  function automatic int unsigned calc_log2ratio(input int unsigned r_w, input int unsigned w_w);
    return $clog2(r_w / w_w);
  endfunction

  function automatic int unsigned calc_level_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned calc_almost_full_dflt(input int unsigned addr_w,
                                                        input int unsigned ratio);
    return (32'd1 << addr_w) - ratio;
  endfunction

endpackage

// File: rtl/iob_asym_fifo_ptr.sv
// Wrapping pointer counter with increment enable and synchronous clear.
module iob_asym_fifo_ptr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // next pointer: clear wins over increment, wrap is natural modulo 2**W
  always_comb begin
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/iob_asym_fifo_ctrl.sv
// Single-clock controller for an asymmetric FIFO memory (narrow pushes, wide pops).
// Optional almost_full/almost_empty outputs are enabled by IOB_ASYM_FIFO_ALMOST_EN.
module iob_asym_fifo_ctrl
  import iob_asym_fifo_pkg::*;
#(
  parameter int unsigned W_DATA_W = 8,
  parameter int unsigned R_DATA_W = 32,
  parameter int unsigned W_ADDR_W = 6,
`ifdef IOB_ASYM_FIFO_ALMOST_EN
  parameter int unsigned ALMOST_FULL_LVL =
    calc_almost_full_dflt(W_ADDR_W, calc_ratio(R_DATA_W, W_DATA_W)),
`endif
  localparam int unsigned R_ADDR_W = W_ADDR_W - calc_log2ratio(R_DATA_W, W_DATA_W),
  localparam int unsigned LVL_W    = calc_level_w(W_ADDR_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic [W_DATA_W-1:0] push_data,
  input  logic                pop,
  output logic [R_DATA_W-1:0] pop_data,
  output logic                pop_valid,
  output logic                full,
  output logic                empty,
  output logic [LVL_W-1:0]    level,
  output logic                overflow,
  output logic                underflow,
`ifdef IOB_ASYM_FIFO_ALMOST_EN
  output logic                almost_full,
  output logic                almost_empty,
`endif
  output logic                mem_w_en,
  output logic [W_ADDR_W-1:0] mem_w_addr,
  output logic [W_DATA_W-1:0] mem_w_data,
  output logic                mem_r_en,
  output logic [R_ADDR_W-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0] mem_r_data
);

  localparam int unsigned     RATIO   = calc_ratio(R_DATA_W, W_DATA_W);
  localparam logic [LVL_W-1:0] CAP_L   = LVL_W'(2 ** W_ADDR_W);
  localparam logic [LVL_W-1:0] RATIO_L = LVL_W'(RATIO);

  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full_s, empty_s, push_acc_s, pop_acc_s;

  // flags come from the registered level only, so a same-cycle pop never frees room for a push
  assign full_s     = (level_q == CAP_L);
  assign empty_s    = (level_q < RATIO_L);
  assign push_acc_s = push & ~full_s & ~flush;
  assign pop_acc_s  = pop & ~empty_s & ~flush;

  iob_asym_fifo_ptr #(.W(W_ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (push_acc_s),
    .ptr_o (mem_w_addr)
  );

  iob_asym_fifo_ptr #(.W(R_ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (pop_acc_s),
    .ptr_o (mem_r_addr)
  );

  // next-state level, sticky error flags and read-valid pipeline
  always_comb begin
    level_d     = level_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      level_d     = level_q + {{(LVL_W-1){1'b0}}, push_acc_s} - (pop_acc_s ? RATIO_L : '0);
      pop_valid_d = pop_acc_s;
      overflow_d  = overflow_q | (push & full_s);
      underflow_d = underflow_q | (pop & empty_s);
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef IOB_ASYM_FIFO_ALMOST_EN
  logic almost_full_q, almost_empty_q;

  // almost flags track the next-state level so they align with level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (level_d >= LVL_W'(ALMOST_FULL_LVL));
      almost_empty_q <= (level_d < LVL_W'(ALMOST_EMPTY_WIDE * RATIO));
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  assign mem_w_en   = push_acc_s;
  assign mem_w_data = push_data;
  assign mem_r_en   = pop_acc_s;
  assign pop_data   = mem_r_data;
  assign pop_valid  = pop_valid_q;
  assign full       = full_s;
  assign empty      = empty_s;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Self-checking bench for iob_asym_fifo_ctrl: directed and random traffic against a byte-queue model.
`timescale 1ns/1ps
module tb_iob_asym_fifo_ctrl;

  localparam int RATIO = 4;
  localparam int CAP   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [7:0]  push_data = 8'h00;
  logic [31:0] pop_data;
  logic [31:0] mem_r_data;
  logic        pop_valid, full, empty, overflow, underflow, mem_w_en, mem_r_en;
  logic [6:0]  level;
  logic [5:0]  mem_w_addr;
  logic [7:0]  mem_w_data;
  logic [3:0]  mem_r_addr;
`ifdef IOB_ASYM_FIFO_ALMOST_EN
  logic        almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  iob_asym_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
`ifdef IOB_ASYM_FIFO_ALMOST_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .mem_w_en     (mem_w_en),
    .mem_w_addr   (mem_w_addr),
    .mem_w_data   (mem_w_data),
    .mem_r_en     (mem_r_en),
    .mem_r_addr   (mem_r_addr),
    .mem_r_data   (mem_r_data)
  );

  // asymmetric memory: narrow writes, registered wide reads, lane k at narrow address {a,k}
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) begin
      for (int k = 0; k < RATIO; k++) mem_r_data[k*8 +: 8] <= mem[{mem_r_addr, 2'(k)}];
    end
  end

  // reference model
  logic [7:0]  q[$];
  bit          exp_valid, exp_ovf, exp_unf;
  logic [31:0] exp_word;
  int          exp_wr, exp_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    exp_wr    = 0;
    exp_rd    = 0;
  endtask

  task automatic check_state();
    chk("level", level, q.size());
    chk("full", full, q.size() == CAP);
    chk("empty", empty, q.size() < RATIO);
    chk("pop_valid", pop_valid, exp_valid);
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_unf);
    if (exp_valid) chk("pop_data", pop_data, exp_word);
`ifdef IOB_ASYM_FIFO_ALMOST_EN
    chk("almost_full", almost_full, q.size() >= CAP - RATIO);
    chk("almost_empty", almost_empty, q.size() < 2 * RATIO);
`endif
  endtask

  // one clock: drive after the falling edge, check strobes, step model, check state at next falling edge
  task automatic cycle(input bit p, input logic [7:0] d, input bit o, input bit f);
    bit ap, ao;
    push = p; push_data = d; pop = o; flush = f;
    #1;
    ap = p && (q.size() < CAP) && !f;
    ao = o && (q.size() >= RATIO) && !f;
    chk("mem_w_en", mem_w_en, ap);
    chk("mem_r_en", mem_r_en, ao);
    if (ap) begin
      chk("mem_w_data", mem_w_data, d);
      chk("mem_w_addr", mem_w_addr, exp_wr);
    end
    if (ao) chk("mem_r_addr", mem_r_addr, exp_rd);
    if (f) begin
      model_clear();
    end else begin
      if (p && !ap) exp_ovf = 1'b1;
      if (o && !ao) exp_unf = 1'b1;
      if (ao) begin
        for (int k = 0; k < RATIO; k++) exp_word[k*8 +: 8] = q.pop_front();
        exp_rd = (exp_rd + 1) % 16;
      end
      if (ap) begin
        q.push_back(d);
        exp_wr = (exp_wr + 1) % CAP;
      end
      exp_valid = ao;
    end
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    check_state();
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  initial begin
    int pushes, pops, budget;
    bit p, o;
    model_clear();
    repeat (2) @(negedge clk);
    check_state();
    rst_n = 1'b1;
    @(negedge clk);

    // basic lane order
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    chk("level_4", level, 7'd4);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lane_order", pop_data, 32'h4433_2211);
    chk("drained_empty", empty, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // partial word is unreadable
    push_n(3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("partial_underflow", underflow, 1'b1);
    chk("partial_level", level, 7'd3);
    push_n(1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // fill to capacity, overflow, pop+push when full
    push_n(CAP);
    chk("full_at_64", full, 1'b1);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("overflow_set", overflow, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("full_pop_push_level", level, 7'd60);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // random interleave with pointer wrap, level held in [8,40]
    push_n(8);
    pushes = 0; pops = 0; budget = 0;
    while ((pushes < 200 || pops < 50) && budget < 3000) begin
      p = (pushes < 200) && (q.size() < 40) && ($urandom_range(0, 3) != 0);
      o = (pops < 50) && (q.size() >= 12) && ($urandom_range(0, 3) == 0 || pushes >= 200);
      if (p) pushes++;
      if (o) pops++;
      cycle(p, 8'($urandom_range(0, 255)), o, 1'b0);
      budget++;
    end
    chk("random_loop_budget", budget < 3000, 1'b1);

    // simultaneous push and pop at level 8, then flush with requests asserted
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    push_n(8);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("sim_push_pop_level", level, 7'd5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow_before_flush", underflow, 1'b1);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    chk("flush_level", level, 7'd0);
    chk("flush_underflow", underflow, 1'b0);

    // asynchronous reset while pop_valid is high
    push_n(4);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_valid_before_reset", pop_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef IOB_ASYM_FIFO_ALMOST_EN
    push_n(8);
    chk("almost_empty_at_8", almost_empty, 1'b0);
    push_n(52);
    chk("almost_full_at_60", almost_full, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
